// File: rtl/clm_inv_seq_pkg.sv
// Shared masking types and GF(2^8) helpers for the masked inversion sequencer.
// Field is GF(2^8) modulo x^8+x^4+x^3+x+1; shares combine by XOR.
package clm_inv_seq_pkg;

  // Masking order: share count of every masked operand.
  localparam int D  = 2;
  // One fresh byte per share pair for the masked multiplier.
  localparam int NR = D * (D - 1) / 2;

  typedef logic [D-1:0][7:0] state_t;
  // Bytes [NR-1:0] feed the multiplier cross terms; byte [NR] seeds the refresh mask.
  typedef logic [NR:0][7:0]  red_poly_t;
  // Row k selects which seed bits fold into refresh mask bit k.
  typedef logic [7:0][7:0]   nm_matrix_t;

  typedef enum logic [1:0] {
    POW1 = 2'd0,
    POW2 = 2'd1,
    POW4 = 2'd2
  } pow_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

endpackage

// File: rtl/clm_step.sv
// Combinational masked step: one power chain (x^2, x^4, x^16) or one masked multiply.
// Zero latency, no flow control; caller selects the operation each cycle.
module clm_step
  import clm_inv_seq_pkg::*;
#(
  parameter int d = D
) (
  input  logic       op_mul,
  input  pow_t       pow_sel,
  input  state_t     op_a,
  input  state_t     op_b,
  input  red_poly_t  r,
  input  nm_matrix_t B_ext,
  output state_t     res
);

  state_t     p1, p2, p3, p4;
  state_t     pw;
  state_t     mul;
  logic [7:0] m;
  logic [7:0] z;

  always_comb begin
    p1  = '0;
    p2  = '0;
    p3  = '0;
    p4  = '0;
    pw  = '0;
    mul = '0;
    m   = '0;
    z   = '0;
    res = '0;

    for (int k = 0; k < 8; k++) m[k] = ^(B_ext[k] & r[NR]);

    // Squaring is linear in GF(2^8), so it acts share by share.
    for (int i = 0; i < d; i++) begin
      p1[i] = gf_sq(op_a[i]);
      p2[i] = gf_sq(p1[i]);
      p3[i] = gf_sq(p2[i]);
      p4[i] = gf_sq(p3[i]);
    end

    case (pow_sel)
      POW2:    pw = p2;
      POW4:    pw = p4;
      default: pw = p1;
    endcase
    // Same mask on two shares keeps the XOR sum; with one share it cancels.
    pw[0]   = pw[0] ^ m;
    pw[d-1] = pw[d-1] ^ m;

    for (int i = 0; i < d; i++) mul[i] = gf_mul(op_a[i], op_b[i]);
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        z      = r[i*d - (i*(i+1))/2 + (j-i-1)]
               ^ gf_mul(op_a[i], op_b[j]) ^ gf_mul(op_a[j], op_b[i]);
        mul[i] = mul[i] ^ r[i*d - (i*(i+1))/2 + (j-i-1)];
        mul[j] = mul[j] ^ z;
      end
    end

    res = op_mul ? mul : pw;
  end

endmodule

// File: rtl/clm_inv_seq.sv
// Masked GF(2^8) inverse x^254 over a 7-step addition chain; accept at N, out_valid at N+8.
// in_ready only in IDLE; result held in DONE until out_ready, one operation per 9 cycles at best.
module clm_inv_seq
  import clm_inv_seq_pkg::*;
#(
  // Must equal the package share count, which sizes state_t.
  parameter int d = D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in,
  input  red_poly_t  r,
  input  nm_matrix_t B_ext,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SQ1    = 4'd1,
    MUL3   = 4'd2,
    P4     = 4'd3,
    MUL15  = 4'd4,
    P16    = 4'd5,
    MUL14  = 4'd6,
    MUL254 = 4'd7,
    DONE   = 4'd8
  } seq_state_t;

  seq_state_t state, next_state;

  state_t x_q, a_q, b_q, c_q, e_q, res_q;
  state_t op_a, op_b, step_res;
  logic   op_mul;
  pow_t   pow_sel;

  clm_step #(.d(d)) u_step (
    .op_mul  (op_mul),
    .pow_sel (pow_sel),
    .op_a    (op_a),
    .op_b    (op_b),
    .r       (r),
    .B_ext   (B_ext),
    .res     (step_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    op_mul     = 1'b0;
    pow_sel    = POW1;
    op_a       = x_q;
    op_b       = x_q;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = SQ1;
      end
      SQ1: begin
        pow_sel    = POW1;
        op_a       = x_q;
        next_state = MUL3;
      end
      MUL3: begin
        op_mul     = 1'b1;
        op_a       = a_q;
        op_b       = x_q;
        next_state = P4;
      end
      P4: begin
        pow_sel    = POW2;
        op_a       = b_q;
        next_state = MUL15;
      end
      MUL15: begin
        op_mul     = 1'b1;
        op_a       = c_q;
        op_b       = b_q;
        next_state = P16;
      end
      P16: begin
        pow_sel    = POW4;
        op_a       = e_q;
        next_state = MUL14;
      end
      MUL14: begin
        op_mul     = 1'b1;
        op_a       = c_q;
        op_b       = a_q;
        next_state = MUL254;
      end
      MUL254: begin
        op_mul     = 1'b1;
        op_a       = e_q;
        op_b       = c_q;
        next_state = DONE;
      end
      DONE: begin
        // A new operand offered alongside out_ready waits for IDLE.
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // a=x^2, b=x^3, c=x^12 then x^14, e=x^15 then x^240, res=x^254.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      e_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE:    if (in_valid) x_q <= in;
        SQ1:     a_q   <= step_res;
        MUL3:    b_q   <= step_res;
        P4:      c_q   <= step_res;
        MUL15:   e_q   <= step_res;
        P16:     e_q   <= step_res;
        MUL14:   c_q   <= step_res;
        MUL254:  res_q <= step_res;
        default: ;
      endcase
    end
  end

  assign out = res_q;

endmodule

// File: doc/clm_inv_seq.md
CLM_INV_SEQ -- requirements
Module: clm_inv_seq

Interface
REQ-001 Parameter: d, default d (package value), masking order; sets share count of state_t.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  in  1  upstream operand valid.
REQ-005 Port: in_ready  out  1  block can accept operand.
REQ-006 Port: in  in  state_t  masked CLM operand x.
REQ-007 Port: r  in  red_poly_t  fresh reduction randomness; sampled every computing cycle.
REQ-008 Port: B_ext  in  nm_matrix_t  extension matrix; held stable for the whole operation.
REQ-009 Port: out_valid  out  1  result valid.
REQ-010 Port: out_ready  in  1  downstream accepts result.
REQ-011 Port: out  out  state_t  masked x^254 (GF(2^8) inverse; 0 maps to 0).
REQ-012 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 Computes x^254 via fixed addition chain, one step per cycle, results registered.
REQ-014 States: IDLE, SQ1, MUL3, P4, MUL15, P16, MUL14, MUL254, DONE.
REQ-015 IDLE: in_ready=1; on in_valid register x, go SQ1; else stay.
REQ-016 SQ1: a <= x^2 (power, pow=1).
REQ-017 MUL3: b <= a*x (x^3).
REQ-018 P4: c <= b^4 (power, pow=2) (x^12).
REQ-019 MUL15: e <= c*b (x^15).
REQ-020 P16: e <= e^16 (power, pow=4) (x^240).
REQ-021 MUL14: c <= c*a (x^14).
REQ-022 MUL254: res <= e*c (x^254); go DONE.
REQ-023 DONE: out_valid=1, out=res; on out_ready go IDLE; else hold out stable.
REQ-024 Latency: accept at cycle N -> out_valid at N+8; throughput one operation per 9 cycles min.
REQ-025 in_ready low in all states except IDLE; in_valid ignored while busy.
REQ-026 Every power/multiply step uses the r value present in that cycle; never reuses a latched r across steps.
REQ-027 out holds last result after leaving DONE; out_valid low outside DONE.
REQ-028 Same-cycle out_ready and new in_valid in DONE: result retired, new operand NOT accepted until IDLE.

Reset
REQ-029 rst high at any clock edge: state <= IDLE, out_valid=0, busy=0, in_ready=1, all data registers (x,a,b,c,e,res) <= 0.
REQ-030 rst mid-operation aborts it; no partial result ever presented.

Structure
REQ-031 state_t, red_poly_t, nm_matrix_t, d in shared package types (clm_typedefs.svh); FSM state enum local.
REQ-032 One sub-module natural: clm_step, a combinational datapath muxing power(pow=1/2/4) and shared masked multiplier by state; only one power chain active per cycle.

Verification
REQ-033 Unmasked-equivalent x=0x02 -> decoded out=0x8D after 8 cycles; out_valid single pulse with out_ready=1.
REQ-034 x=0x00 -> decoded out=0x00; x=0x01 -> 0x01; x=0x53 -> 0xCA.
REQ-035 Exhaustive 256 inputs with random masks/r each cycle -> decoded out equals AES S-box inverse table.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid and out stable, in_ready=0; then in_valid accepted only after return to IDLE.
REQ-037 rst asserted in P16 -> next cycle IDLE, out_valid=0, in_ready=1; next operand x=0x02 yields 0x8D.
